// File: rtl/matrix_text_renderer.sv
// Renders a grid of BCD-decimal matrix cells as 8x16 glyphs onto a VGA raster and accepts cell writes.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits (last digit always drawn).
module matrix_text_renderer #(
    parameter int          X0         = 100,
    parameter int          Y0         = 50,
    parameter int          NUM_MAT    = 3,
    parameter int          MATRIX_N   = 3,
    parameter int          MATRIX_M   = 3,
    parameter int          DIGITS     = 5,
    parameter int          DATA_W     = 16,
    parameter int          CELL_PITCH = 55,
    parameter int          MAT_PITCH  = 165,
    parameter int          ROW_PITCH  = 30,
    parameter logic [11:0] FG         = 12'hFFF,
    parameter logic [11:0] BG         = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       h_count,
    input  logic [10:0]       v_count,
    input  logic              blank,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_mat,
    input  logic [7:0]        wr_row,
    input  logic [7:0]        wr_col,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    output logic              wr_ovf,
    output logic              pix_on,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b
);
    localparam int NCELLS = NUM_MAT * MATRIX_N * MATRIX_M;
    localparam int IDX_W  = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam int CW     = 4 * DIGITS;
    localparam int CNT_W  = $clog2(DATA_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    // Row 0 of each glyph sits in the top byte; bit 7 of a byte is the leftmost pixel.
    function automatic logic [127:0] glyph_rom(input logic [3:0] d);
        case (d)
            4'd0:    glyph_rom = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            4'd1:    glyph_rom = 128'h00001838781818181818187E00000000;
            4'd2:    glyph_rom = 128'h00007CC6060C183060C0C6FE00000000;
            4'd3:    glyph_rom = 128'h00007CC606063C060606C67C00000000;
            4'd4:    glyph_rom = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            4'd5:    glyph_rom = 128'h0000FEC0C0C0FC060606C67C00000000;
            4'd6:    glyph_rom = 128'h00003860C0C0FCC6C6C6C67C00000000;
            4'd7:    glyph_rom = 128'h0000FEC606060C183030303000000000;
            4'd8:    glyph_rom = 128'h00007CC6C6C67CC6C6C6C67C00000000;
            4'd9:    glyph_rom = 128'h00007CC6C6C67E0606060C7800000000;
            default: glyph_rom = 128'h0;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    // Reset asserts asynchronously; its release is re-timed to clk through two flops.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst;
    assign rst_sync_d = {rst_sync_q[0], 1'b0};
    assign rst        = rst_sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_sync_q <= 2'b11;
        else       rst_sync_q <= rst_sync_d;
    end

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [CW-1:0]     bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              wr_err_q, wr_err_d;
    logic [CW-1:0]     cells_q [NCELLS];
    logic [CW-1:0]     cells_d [NCELLS];

    // Write handshake: a transfer happens on a clk edge where wr_valid && wr_ready; wr_ready is high only in IDLE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        wr_err_d = 1'b0;
        cells_d  = cells_q;
        bcd_adj  = bcd_q;
        wr_ready = 1'b0;
        wr_ovf   = 1'b0;
        case (state_q)
            IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    if (int'(wr_mat) >= NUM_MAT || int'(wr_row) >= MATRIX_N || int'(wr_col) >= MATRIX_M) begin
                        wr_err_d = 1'b1;
                    end else begin
                        idx_d   = IDX_W'((int'(wr_mat) * MATRIX_N + int'(wr_row)) * MATRIX_M + int'(wr_col));
                        bin_d   = wr_data;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = (64'(wr_data) > MAX_VAL);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                for (int d = 0; d < DIGITS; d++) begin
                    if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
                end
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = COMMIT;
            end
            COMMIT: begin
                wr_ovf         = ovf_q;
                cells_d[idx_q] = ovf_q ? {DIGITS{4'h9}} : bcd_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Render stage 1 locates the digit under the beam and reads the glyph ROM; stage 2 picks the bit.
    logic [7:0]   glyph_q, glyph_d;
    logic [2:0]   bitx_q, bitx_d;
    logic         hit_q, hit_d;
    logic         blank_q;
    logic         pix_on_q, pix_on_d;
    logic [11:0]  rgb_q, rgb_d;
    logic [3:0]   digit, grow;
    logic [CW-1:0] cell_w;
    logic [IDX_W-1:0] cidx;
    logic [127:0] font_w;
    logic         lead, lit;
    int           hx, vy, xl, yl;

    always_comb begin
        hit_d  = 1'b0;
        lead   = 1'b0;
        digit  = '0;
        grow   = '0;
        bitx_d = '0;
        cell_w = '0;
        cidx   = '0;
        xl     = 0;
        yl     = 0;
        hx     = int'(h_count);
        vy     = int'(v_count);
        for (int j = 0; j < NUM_MAT; j++) begin
            for (int i = 0; i < MATRIX_N; i++) begin
                for (int k = 0; k < MATRIX_M; k++) begin
                    for (int l = 0; l < DIGITS; l++) begin
                        xl = X0 + 8 * l + CELL_PITCH * k + MAT_PITCH * j;
                        yl = Y0 + ROW_PITCH * i;
                        if (hx >= xl && hx < xl + 8 && vy >= yl && vy < yl + 16) begin
                            hit_d  = 1'b1;
                            cidx   = IDX_W'((j * MATRIX_N + i) * MATRIX_M + k);
                            cell_w = cells_q[cidx];
                            digit  = cell_w[4*(DIGITS-1-l) +: 4];
                            grow   = 4'(vy - yl);
                            bitx_d = 3'(hx - xl);
`ifdef LEADING_ZERO_BLANK_EN
                            lead = (l < DIGITS - 1);
                            for (int d = 0; d < DIGITS - 1; d++) begin
                                if (d <= l && cell_w[4*(DIGITS-1-d) +: 4] != 4'd0) lead = 1'b0;
                            end
`else
                            lead = 1'b0;
`endif
                        end
                    end
                end
            end
        end
        font_w  = glyph_rom(digit);
        glyph_d = font_w[8*(15 - int'(grow)) +: 8];
    end

    always_comb begin
        lit      = hit_q && glyph_q[3'd7 - bitx_q];
        pix_on_d = lit && !blank_q;
        rgb_d    = blank_q ? 12'h000 : (lit ? FG : BG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            wr_err_q <= 1'b0;
            for (int c = 0; c < NCELLS; c++) cells_q[c] <= '0;
            glyph_q  <= '0;
            bitx_q   <= '0;
            hit_q    <= 1'b0;
            blank_q  <= 1'b1;
            pix_on_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            wr_err_q <= wr_err_d;
            cells_q  <= cells_d;
            glyph_q  <= glyph_d;
            bitx_q   <= bitx_d;
            hit_q    <= hit_d && !lead;
            blank_q  <= blank;
            pix_on_q <= pix_on_d;
            rgb_q    <= rgb_d;
        end
    end

    assign wr_err = wr_err_q;
    assign pix_on = pix_on_q;
    assign vga_r  = rgb_q[11:8];
    assign vga_g  = rgb_q[7:4];
    assign vga_b  = rgb_q[3:0];
endmodule

// File: doc/matrix_text_renderer.md
MATRIX_TEXT_RENDERER -- requirements
Module: matrix_text_renderer

Interface
REQ-001 SHALL have parameters: X0=100, left pixel of matrix 0; Y0=50, top line of row 0; NUM_MAT=3, matrices across; MATRIX_N=3, rows; MATRIX_M=3, columns; DIGITS=5, decimal digits per cell; DATA_W=16, cell value width; CELL_PITCH=55, column pitch in pixels; MAT_PITCH=165, matrix pitch; ROW_PITCH=30, row pitch; FG=12'hFFF and BG=12'h000, RGB444 colours.
REQ-002 SHALL have ports: clk in 1, system clock; reset in 1, asynchronous active-high reset.
REQ-003 SHALL have ports: h_count in 11, v_count in 11, current pixel position; blank in 1, high outside the active area.
REQ-004 SHALL have ports: wr_valid in 1, wr_ready out 1, write handshake; wr_mat in 8, wr_row in 8, wr_col in 8, target cell; wr_data in DATA_W, unsigned value.
REQ-005 SHALL have ports: wr_err out 1, one-cycle pulse for an out-of-range address; wr_ovf out 1, one-cycle pulse for a saturated value.
REQ-006 SHALL have ports: pix_on out 1, glyph pixel lit; vga_r, vga_g, vga_b out 4 each, colour output.

Function
REQ-007 SHALL store NUM_MAT*MATRIX_N*MATRIX_M cells, each holding DIGITS BCD digits; digit 0 is the most significant.
REQ-008 SHALL place digit l of cell (mat j, row i, col k) in x range [X0+8l+CELL_PITCH*k+MAT_PITCH*j, +8) and y range [Y0+ROW_PITCH*i, +16).
REQ-009 SHALL render each digit from an internal synchronous 8x16 glyph ROM for 0-9; bit 7 of a glyph row is the leftmost pixel.
REQ-010 SHALL run the render pipeline on every clk, with vga_*/pix_on registered exactly 2 clk cycles after h_count/v_count/blank are sampled.
REQ-011 SHALL drive pix_on=1 and RGB=FG when the pixel lies on a lit glyph bit and blank was 0; otherwise pix_on=0 and RGB=BG; while blank is 1, RGB SHALL be 0 regardless of BG.
REQ-012 SHALL implement the write FSM with states IDLE, SHIFT and COMMIT; wr_ready=1 only in IDLE.
REQ-013 IDLE: a transfer is wr_valid&&wr_ready; it captures the address and data and moves to SHIFT.
REQ-014 SHALL, when any address field is out of range (wr_mat>=NUM_MAT, wr_row>=MATRIX_N, wr_col>=MATRIX_M), pulse wr_err one cycle later, leave the buffer unchanged, and stay in IDLE.
REQ-015 SHIFT: double-dabble binary-to-BCD conversion, one bit per clk, lasting DATA_W cycles, followed by COMMIT.
REQ-016 COMMIT: all digits of the cell SHALL be written in one cycle (atomic per cell, no partial cell visible), then return to IDLE; wr_ready SHALL be low for exactly DATA_W+1 cycles after a valid transfer.
REQ-017 SHALL, when the value exceeds 10^DIGITS-1, write all digits as 9 and pulse wr_ovf during COMMIT.
REQ-018 SHALL read the old cell contents during the COMMIT cycle; the new contents SHALL be used from the next cycle.

Reset
REQ-019 SHALL, while reset is high (async assert, release synchronised to clk): FSM in IDLE, all cells hold 0, wr_ready=1, wr_err=0, wr_ovf=0, pix_on=0, vga_*=0.
REQ-020 SHALL, on reset asserted mid-conversion, abort the conversion and discard the captured value; the target cell reads 0.

Configuration
REQ-021 SHALL provide macro LEADING_ZERO_BLANK_EN.
REQ-022 With LEADING_ZERO_BLANK_EN defined, leading zero digits SHALL render unlit; the least significant digit SHALL always render.
REQ-023 Without LEADING_ZERO_BLANK_EN, all DIGITS digits SHALL render, zero-padded.

Verification
REQ-024 Reset, then sweep h=100..107, v=50..65, blank=0 -> pix_on after 2 cycles matches glyph '0' rows 0..15 (macro off).
REQ-025 Write mat=1,row=2,col=0,data=12345 -> wr_ready low 17 cycles; cell at x=265..304, y=110..125 shows "12345".
REQ-026 Write row=3 -> wr_err pulse, wr_ready stays 1; DIGITS=4 instance with data=65535 -> wr_ovf pulse, cell shows "9999".
REQ-027 blank=1 over a lit glyph pixel -> vga_r/g/b=0, pix_on=0.
REQ-028 Reset asserted at SHIFT cycle 5 of writing 999 -> wr_ready=1 after release, cell shows "00000".
REQ-029 Write 42 with the macro defined -> "   42"; write 0 -> only the rightmost '0' lit; without the macro, 42 -> "00042".
